// File: rtl/ee357_mcpu_cu_ext_pkg.sv
// EE357 multicycle MIPS control unit: shared opcodes, states
// and datapath select encodings.
package ee357_mcpu_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_LWWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_ILLEGAL = 2'b01,
    EXC_TIMEOUT = 2'b10
  } cause_t;

  localparam logic [1:0] MTOR_ALU = 2'b00;
  localparam logic [1:0] MTOR_MDR = 2'b01;
  localparam logic [1:0] MTOR_PC  = 2'b10;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_4     = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_TGT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_REG = 2'b11;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ee357_mcpu_cu_ext_if.sv
// Control unit <-> IR/memory/datapath bundle.
// master = control unit, slave = datapath side.
interface ee357_mcpu_cu_ext_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       mem_rdy;
  logic       pcw;
  logic       pcwc;
  logic       iord;
  logic       mr;
  logic       mw;
  logic       irw;
  logic       regw;
  logic       alusela;
  logic       tw;
  logic       brne;
  logic [1:0] mtor;
  logic [1:0] rdst;
  logic [1:0] aluselb;
  logic [1:0] aluop;
  logic [1:0] pcs;
  logic       exc;
  logic [1:0] exc_cause;
  logic [3:0] state;

  modport master (
    input  op, func, mem_rdy,
    output pcw, pcwc, iord, mr, mw, irw,
    output regw, alusela, tw, brne,
    output mtor, rdst, aluselb, aluop, pcs,
    output exc, exc_cause, state
  );

  modport slave (
    output op, func, mem_rdy,
    input  pcw, pcwc, iord, mr, mw, irw,
    input  regw, alusela, tw, brne,
    input  mtor, rdst, aluselb, aluop, pcs,
    input  exc, exc_cause, state
  );
endinterface

// File: rtl/ee357_mcpu_cu_ext_wait_timer.sv
// Memory wait-state counter; flags the wait cycle that
// would reach WAIT_LIMIT.
module ee357_mcpu_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(WAIT_LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 8'd1;
  end

  // a ready cycle never increments, so it can never time out
  assign timeout = inc && (cnt == LAST);

endmodule

// File: rtl/ee357_mcpu_cu_ext.sv
// Multicycle MIPS control unit with ADDI/JAL/JR/BNE,
// memory wait states and an exception trap.
module ee357_mcpu_cu_ext
  import ee357_mcpu_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_LIMIT    = 15,
  parameter bit TRAP_HALT     = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  ee357_mcpu_cu_ext_if.master bus
);

  state_t state, state_n;
  cause_t cause, cause_n;
  logic   bne_q, bne_n;
  logic   rdy;
  logic   wait_inc;
  logic   wait_clr;
  logic   timeout;

  assign rdy      = MEM_HANDSHAKE ? bus.mem_rdy : 1'b1;
  assign wait_inc = MEM_HANDSHAKE && is_mem_state(state)
                    && !bus.mem_rdy;
  assign wait_clr = (state_n != state);

  if (MEM_HANDSHAKE) begin : g_wait
    ee357_mcpu_wait_timer #(
      .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (wait_clr),
      .inc    (wait_inc),
      .timeout(timeout)
    );
  end else begin : g_nowait
    assign timeout = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cause <= EXC_NONE;
      bne_q <= 1'b0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      bne_q <= bne_n;
    end
  end

  always_comb begin
    state_n = state;
    cause_n = cause;
    bne_n   = bne_q;
    unique case (state)
      S_FETCH: begin
        if (rdy) state_n = S_DECODE;
        else if (timeout) begin
          state_n = S_TRAP;
          cause_n = EXC_TIMEOUT;
        end
      end
      S_DECODE: begin
        // latched so BRANCH never looks at op again
        bne_n = (bus.op == OP_BNE);
        unique case (1'b1)
          (bus.op == OP_LW) || (bus.op == OP_SW):
            state_n = S_MEMADR;
          (bus.op == OP_RTYPE) && (bus.func == FUNC_JR):
            state_n = S_JR;
          (bus.op == OP_RTYPE) && (bus.func != FUNC_JR):
            state_n = S_REXEC;
          (bus.op == OP_BEQ) || (bus.op == OP_BNE):
            state_n = S_BRANCH;
          (bus.op == OP_J):
            state_n = S_JUMP;
          (bus.op == OP_ADDI):
            state_n = S_IEXEC;
          (bus.op == OP_JAL):
            state_n = S_JAL;
          default: begin
            state_n = S_TRAP;
            cause_n = EXC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:
        state_n = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (rdy) state_n = S_LWWB;
        else if (timeout) begin
          state_n = S_TRAP;
          cause_n = EXC_TIMEOUT;
        end
      end
      S_MEMWR: begin
        if (rdy) state_n = S_FETCH;
        else if (timeout) begin
          state_n = S_TRAP;
          cause_n = EXC_TIMEOUT;
        end
      end
      S_REXEC: state_n = S_RWB;
      S_IEXEC: state_n = S_IWB;
      S_TRAP:  if (!TRAP_HALT) state_n = S_FETCH;
      default: state_n = S_FETCH;
    endcase
    if (state_n == S_FETCH) cause_n = EXC_NONE;
  end

  always_comb begin
    bus.pcw     = 1'b0;
    bus.pcwc    = 1'b0;
    bus.iord    = 1'b0;
    bus.mr      = 1'b0;
    bus.mw      = 1'b0;
    bus.irw     = 1'b0;
    bus.regw    = 1'b0;
    bus.alusela = 1'b0;
    bus.tw      = 1'b0;
    bus.brne    = 1'b0;
    bus.exc     = 1'b0;
    bus.mtor    = MTOR_ALU;
    bus.rdst    = RDST_RT;
    bus.aluselb = ALUB_B;
    bus.aluop   = ALUOP_ADD;
    bus.pcs     = PCS_ALU;
    unique case (state)
      S_FETCH: begin
        bus.mr      = 1'b1;
        bus.irw     = rdy;
        bus.pcw     = rdy;
        bus.aluselb = ALUB_4;
      end
      S_DECODE: begin
        bus.tw      = 1'b1;
        bus.aluselb = ALUB_IMMSH;
      end
      S_MEMADR: begin
        bus.iord    = 1'b1;
        bus.alusela = 1'b1;
        bus.aluselb = ALUB_IMM;
      end
      S_MEMRD: begin
        bus.iord    = 1'b1;
        bus.mr      = 1'b1;
        bus.alusela = 1'b1;
        bus.aluselb = ALUB_IMM;
      end
      S_LWWB: begin
        bus.iord    = 1'b1;
        bus.mr      = 1'b1;
        bus.regw    = 1'b1;
        bus.mtor    = MTOR_MDR;
        bus.alusela = 1'b1;
        bus.aluselb = ALUB_IMM;
      end
      S_MEMWR: begin
        bus.iord    = 1'b1;
        bus.mw      = 1'b1;
        bus.alusela = 1'b1;
        bus.aluselb = ALUB_IMM;
      end
      S_REXEC: begin
        bus.alusela = 1'b1;
        bus.aluop   = ALUOP_FUNC;
      end
      S_RWB: begin
        bus.regw    = 1'b1;
        bus.rdst    = RDST_RD;
        bus.alusela = 1'b1;
        bus.aluop   = ALUOP_FUNC;
      end
      S_BRANCH: begin
        bus.pcwc    = 1'b1;
        bus.alusela = 1'b1;
        bus.aluop   = ALUOP_SUB;
        bus.pcs     = PCS_TGT;
        bus.brne    = bne_q;
      end
      S_JUMP: begin
        bus.pcw = 1'b1;
        bus.pcs = PCS_JMP;
      end
      S_IEXEC, S_IWB: begin
        bus.regw    = (state == S_IWB);
        bus.alusela = 1'b1;
        bus.aluselb = ALUB_IMM;
      end
      S_JAL: begin
        bus.pcw  = 1'b1;
        bus.pcs  = PCS_JMP;
        bus.regw = 1'b1;
        bus.rdst = RDST_RA;
        bus.mtor = MTOR_PC;
      end
      S_JR: begin
        bus.pcw = 1'b1;
        bus.pcs = PCS_REG;
      end
      S_TRAP: bus.exc = 1'b1;
      default: ;
    endcase
  end

  assign bus.state     = state;
  assign bus.exc_cause = cause;

endmodule

// File: tb/tb_ee357_mcpu_cu_ext.sv
// Scoreboard bench for ee357_mcpu_cu_ext: per-cycle expected
// state/controls queued at drive time, compared per scenario.
module tb_ee357_mcpu_cu_ext;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] cause;
    logic pcw, pcwc, iord, mr, mw, irw;
    logic regw, alusela, tw, brne, exc;
    logic [1:0] mtor, rdst, aluselb, aluop, pcs;
  } obs_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, JAL = 6'b000011;
  localparam logic [5:0] XX = 6'b111111;

  logic clk, rst;
  logic [5:0] op_d, func_d;
  logic rdy_d;
  logic dec_bne;
  int checks, errors;
  obs_t sb[$];
  obs_t obs[$];

  ee357_mcpu_cu_ext_if ba ();
  ee357_mcpu_cu_ext_if bh ();
  ee357_mcpu_cu_ext_if bn ();

  assign ba.op = op_d;  assign ba.func = func_d;
  assign ba.mem_rdy = rdy_d;
  assign bh.op = op_d;  assign bh.func = func_d;
  assign bh.mem_rdy = rdy_d;
  assign bn.op = op_d;  assign bn.func = func_d;
  assign bn.mem_rdy = rdy_d;

  ee357_mcpu_cu_ext dut (.clk(clk), .rst(rst), .bus(ba));
  ee357_mcpu_cu_ext #(.TRAP_HALT(1'b1)) dut_h (
    .clk(clk), .rst(rst), .bus(bh));
  ee357_mcpu_cu_ext #(.MEM_HANDSHAKE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(bn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t exp_of(int s, logic b, logic r,
                                  logic [1:0] c);
    obs_t e;
    e = '0;
    e.st = 4'(s);
    e.cause = c;
    case (s)
      0: begin e.mr = 1; e.irw = r; e.pcw = r; e.aluselb = 2'b01; end
      1: begin e.tw = 1; e.aluselb = 2'b11; end
      2: begin e.iord = 1; e.alusela = 1; e.aluselb = 2'b10; end
      3: begin e.iord = 1; e.mr = 1; e.alusela = 1;
               e.aluselb = 2'b10; end
      4: begin e.iord = 1; e.mr = 1; e.regw = 1; e.mtor = 2'b01;
               e.alusela = 1; e.aluselb = 2'b10; end
      5: begin e.iord = 1; e.mw = 1; e.alusela = 1;
               e.aluselb = 2'b10; end
      6: begin e.alusela = 1; e.aluop = 2'b10; end
      7: begin e.regw = 1; e.rdst = 2'b01; e.alusela = 1;
               e.aluop = 2'b10; end
      8: begin e.pcwc = 1; e.alusela = 1; e.aluop = 2'b01;
               e.pcs = 2'b01; e.brne = b; end
      9: begin e.pcw = 1; e.pcs = 2'b10; end
      10: begin e.alusela = 1; e.aluselb = 2'b10; end
      11: begin e.regw = 1; e.alusela = 1; e.aluselb = 2'b10; end
      12: begin e.pcw = 1; e.pcs = 2'b10; e.regw = 1;
                e.rdst = 2'b10; e.mtor = 2'b10; end
      13: begin e.pcw = 1; e.pcs = 2'b11; end
      14: e.exc = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t snap();
    obs_t g;
    g.st = ba.state;   g.cause = ba.exc_cause;
    g.pcw = ba.pcw;    g.pcwc = ba.pcwc;
    g.iord = ba.iord;  g.mr = ba.mr;
    g.mw = ba.mw;      g.irw = ba.irw;
    g.regw = ba.regw;  g.alusela = ba.alusela;
    g.tw = ba.tw;      g.brne = ba.brne;
    g.exc = ba.exc;    g.mtor = ba.mtor;
    g.rdst = ba.rdst;  g.aluselb = ba.aluselb;
    g.aluop = ba.aluop; g.pcs = ba.pcs;
    return g;
  endfunction

  // one cycle: drive, queue expectation, capture at negedge
  task automatic step(input logic [5:0] o, input logic [5:0] f,
                      input logic r, input int es,
                      input logic [1:0] ec);
    op_d = o; func_d = f; rdy_d = r;
    if (es == 1) dec_bne = (o == BNE);
    sb.push_back(exp_of(es, dec_bne && (es == 8), r, ec));
    @(negedge clk);
    obs.push_back(snap());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; op_d = '0; func_d = '0; rdy_d = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (ba.state !== 4'd0 || ba.pcw !== 1'b0 || ba.irw !== 1'b0
        || ba.mr !== 1'b1 || ba.aluselb !== 2'b01
        || ba.exc_cause !== 2'b00 || ba.regw !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got st=%0d pcw=%b irw=%b mr=%b selb=%b c=%b exp st=0 pcw=0 irw=0 mr=1 selb=01 c=00",
               ba.state, ba.pcw, ba.irw, ba.mr, ba.aluselb,
               ba.exc_cause);
    end
    checks++;
    if (bn.state !== 4'd0 || bn.pcw !== 1'b1 || bn.irw !== 1'b1)
    begin
      errors++;
      $display("FAIL reset_nohs got st=%0d pcw=%b irw=%b exp st=0 pcw=1 irw=1",
               bn.state, bn.pcw, bn.irw);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ba.state !== 4'd0 || bn.state !== 4'd1) begin
      errors++;
      $display("FAIL rdy_gate got hs=%0d nohs=%0d exp hs=0 nohs=1",
               ba.state, bn.state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw_sw();
    int n;
    do_reset();
    step(XX, 0, 1, 0, 0); step(LW, 0, 0, 1, 0);
    step(LW, 0, 0, 2, 0); step(XX, 0, 0, 3, 0);
    step(XX, 0, 0, 3, 0); step(XX, 0, 1, 3, 0);
    step(XX, 0, 0, 4, 0); step(XX, 0, 1, 0, 0);
    step(SW, 0, 0, 1, 0); step(SW, 0, 1, 2, 0);
    step(XX, 0, 0, 5, 0); step(XX, 0, 1, 5, 0);
    step(XX, 0, 1, 0, 0);
    n = 0;
    while (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front(); g = obs.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL lw_sw[%0d] got %h exp %h", n, g, e);
      end
      n++;
    end
  endtask

  task automatic test_rtype_jal();
    int n;
    do_reset();
    step(XX, 0, 1, 0, 0); step(RT, 6'b001000, 1, 1, 0);
    step(XX, XX, 1, 13, 0); step(XX, 0, 1, 0, 0);
    step(RT, 6'b100000, 1, 1, 0); step(XX, XX, 1, 6, 0);
    step(XX, XX, 1, 7, 0); step(XX, 0, 1, 0, 0);
    step(JAL, 0, 0, 1, 0); step(XX, 0, 0, 12, 0);
    step(XX, 0, 1, 0, 0);
    n = 0;
    while (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front(); g = obs.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rtype_jal[%0d] got %h exp %h", n, g, e);
      end
      n++;
    end
  endtask

  task automatic test_branch_jump();
    int n;
    do_reset();
    step(XX, 0, 1, 0, 0); step(BEQ, 0, 1, 1, 0);
    step(BNE, 0, 1, 8, 0); step(XX, 0, 1, 0, 0);
    step(BNE, 0, 1, 1, 0); step(XX, 0, 1, 8, 0);
    step(XX, 0, 1, 0, 0); step(J, 0, 1, 1, 0);
    step(XX, 0, 1, 9, 0); step(XX, 0, 0, 0, 0);
    n = 0;
    while (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front(); g = obs.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL branch[%0d] got %h exp %h", n, g, e);
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    int n;
    do_reset();
    step(XX, 0, 1, 0, 0); step(XX, 0, 1, 1, 0);
    step(XX, 0, 1, 14, 1); step(XX, 0, 0, 0, 0);
    n = 0;
    while (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front(); g = obs.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL illegal[%0d] got %h exp %h", n, g, e);
      end
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      rdy_d = 1'b1;
      @(negedge clk);
      checks++;
      if (bh.state !== 4'd14 || bh.exc !== 1'b1
          || bh.exc_cause !== 2'b01) begin
        errors++;
        $display("FAIL trap_halt[%0d] got st=%0d exc=%b c=%b exp st=14 exc=1 c=01",
                 i, bh.state, bh.exc, bh.exc_cause);
      end
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (bh.state !== 4'd0 || bh.exc_cause !== 2'b00) begin
      errors++;
      $display("FAIL trap_halt_rst got st=%0d c=%b exp st=0 c=00",
               bh.state, bh.exc_cause);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    for (int i = 0; i < 15; i++) step(XX, 0, 0, 0, 0);
    step(XX, 0, 0, 14, 2); step(XX, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) step(XX, 0, 0, 0, 0);
    step(XX, 0, 1, 0, 0); step(J, 0, 0, 1, 0);
    step(XX, 0, 0, 9, 0); step(XX, 0, 1, 0, 0);
    n = 0;
    while (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front(); g = obs.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL timeout[%0d] got %h exp %h", n, g, e);
      end
      n++;
    end
  endtask

  task automatic test_rst_mid();
    int n;
    do_reset();
    step(XX, 0, 1, 0, 0); step(LW, 0, 1, 1, 0);
    step(LW, 0, 1, 2, 0); step(XX, 0, 0, 3, 0);
    step(XX, 0, 0, 3, 0);
    do_reset();
    step(XX, 0, 1, 0, 0); step(ADDI, 0, 1, 1, 0);
    step(XX, 0, 1, 10, 0); step(XX, 0, 1, 11, 0);
    for (int i = 0; i < 10; i++) step(XX, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 14; i++) step(XX, 0, 0, 0, 0);
    step(XX, 0, 1, 0, 0); step(J, 0, 1, 1, 0);
    step(XX, 0, 1, 9, 0);
    n = 0;
    while (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front(); g = obs.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_mid[%0d] got %h exp %h", n, g, e);
      end
      n++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; dec_bne = 1'b0;
    rst = 1'b1; op_d = '0; func_d = '0; rdy_d = 1'b0;
    test_reset();
    test_lw_sw();
    test_rtype_jal();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
